// File: rtl/img_pkg.sv
// Shared constants and FSM state for the pupil-template map writer.
package img_pkg;
  localparam int GRID    = 16;
  localparam int CELLS   = 256;
  localparam int PIX_W   = 10;
  localparam int COORD_W = 13;

  localparam logic [PIX_W-1:0] VAL_DARK   = 10'd0;
  localparam logic [PIX_W-1:0] VAL_BRIGHT = 10'd255;

  typedef enum logic [1:0] {IDLE, ARMED, CAPT, DONE} state_t;
endpackage

// File: rtl/img_block_acc.sv
// Per-column block accumulators: sum a block's pixels, average on its last pixel
// and emit a thresholded map write one cycle later.
module img_block_acc
  import img_pkg::*;
#(
  parameter int HALVING = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [3:0]       cx,
  input  logic [3:0]       cy,
  input  logic             last,
  input  logic [PIX_W-1:0] data,
  input  logic [PIX_W-1:0] thresh,
  output logic             wr_vld,
  output logic [7:0]       wr_cell,
  output logic [PIX_W-1:0] wr_val
);
  localparam int ACC_W = PIX_W + 2*HALVING;

  logic [GRID-1:0][ACC_W-1:0] acc;
  logic [ACC_W-1:0]           sum;
  logic [PIX_W-1:0]           avg;

  assign sum = acc[cx] + ACC_W'(data);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      wr_vld  <= 1'b0;
      wr_cell <= '0;
      avg     <= '0;
    end else begin
      wr_vld <= in_vld && last;
      if (in_vld)
        acc[cx] <= last ? '0 : sum;
      if (in_vld && last) begin
        wr_cell <= {cy, cx};
        avg     <= PIX_W'(sum >> (2*HALVING));
      end
    end
  end

  // Threshold is compared live so it reflects iTHRESH at the moment of the write.
  assign wr_val = (avg >= thresh) ? VAL_BRIGHT : VAL_DARK;
endmodule

// File: rtl/img_capture.sv
// Capture FSM, window decode and 256-cell binary map with a registered read port.
module img_capture
  import img_pkg::*;
#(
  parameter int HALVING = 3,
  parameter int X0      = 0,
  parameter int Y0      = 0
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iSTART,
  input  logic               iDVAL,
  input  logic [COORD_W-1:0] iX,
  input  logic [COORD_W-1:0] iY,
  input  logic [PIX_W-1:0]   iDATA,
  input  logic [PIX_W-1:0]   iTHRESH,
  input  logic [7:0]         iRD_ADDR,
  output logic [PIX_W-1:0]   oRD_VAL,
  output logic               oBUSY,
  output logic               oDONE
);
  localparam int WIN = GRID << HALVING;

  state_t state, nstate;

  logic [COORD_W-1:0] lx, ly;
  logic               in_win, sof, take;

  logic             s1_vld, s1_last;
  logic [3:0]       s1_cx, s1_cy;
  logic [PIX_W-1:0] s1_data;

  logic             wr_vld;
  logic [7:0]       wr_cell;
  logic [PIX_W-1:0] wr_val;

  logic [CELLS-1:0][PIX_W-1:0] map;

  assign lx     = iX - COORD_W'(X0);
  assign ly     = iY - COORD_W'(Y0);
  assign in_win = (iX >= COORD_W'(X0)) && (lx < COORD_W'(WIN)) &&
                  (iY >= COORD_W'(Y0)) && (ly < COORD_W'(WIN));
  assign sof    = (iX == '0) && (iY == '0);
  // The start-of-frame pixel that arms the capture is itself accumulated.
  assign take   = iDVAL && in_win && ((state == CAPT) || (state == ARMED && sof));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_cx   <= '0;
      s1_cy   <= '0;
      s1_data <= '0;
    end else begin
      s1_vld  <= take;
      s1_last <= (&lx[HALVING-1:0]) && (&ly[HALVING-1:0]);
      s1_cx   <= lx[HALVING+3:HALVING];
      s1_cy   <= ly[HALVING+3:HALVING];
      s1_data <= iDATA;
    end
  end

  img_block_acc #(.HALVING(HALVING)) u_acc (
    .clk    (iCLK),
    .rst    (iRST),
    .in_vld (s1_vld),
    .cx     (s1_cx),
    .cy     (s1_cy),
    .last   (s1_last),
    .data   (s1_data),
    .thresh (iTHRESH),
    .wr_vld (wr_vld),
    .wr_cell(wr_cell),
    .wr_val (wr_val)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      map     <= '0;
      oRD_VAL <= '0;
    end else begin
      if (wr_vld)
        map[wr_cell] <= wr_val;
      oRD_VAL <= map[iRD_ADDR];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    oBUSY  = 1'b0;
    oDONE  = 1'b0;
    case (state)
      IDLE:  if (iSTART) nstate = ARMED;
      ARMED: begin
        oBUSY = 1'b1;
        if (take) nstate = CAPT;
      end
      CAPT: begin
        oBUSY = 1'b1;
        if (wr_vld && wr_cell == 8'(CELLS-1)) nstate = DONE;
      end
      DONE: begin
        oDONE  = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end
endmodule

// File: tb/tb_img_capture.sv
// Scoreboarded bench for img_capture: map reads are queued with expected values
// and popped by a monitor as each registered read result appears.
module tb_img_capture;
  logic        iCLK = 1'b0;
  logic        iRST, iSTART, iDVAL;
  logic [12:0] iX, iY;
  logic [9:0]  iDATA, iTHRESH;
  logic [7:0]  iRD_ADDR;
  logic [9:0]  oRD_VAL;
  logic        oBUSY, oDONE;

  always #5 iCLK = ~iCLK;

  img_capture dut (
    .iCLK    (iCLK),
    .iRST    (iRST),
    .iSTART  (iSTART),
    .iDVAL   (iDVAL),
    .iX      (iX),
    .iY      (iY),
    .iDATA   (iDATA),
    .iTHRESH (iTHRESH),
    .iRD_ADDR(iRD_ADDR),
    .oRD_VAL (oRD_VAL),
    .oBUSY   (oBUSY),
    .oDONE   (oDONE)
  );

  typedef struct packed {
    logic [9:0] val;
    logic [7:0] addr;
  } exp_t;

  exp_t       sbq[$];
  logic       rd_issue = 1'b0;
  logic       rd_pend  = 1'b0;
  int         tests = 0, fails = 0;
  int         done_cnt = 0;
  logic [9:0] exp_map [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge iCLK) rd_pend <= rd_issue;

  // Monitor: read data is valid one cycle after the address was presented.
  always @(negedge iCLK) begin
    exp_t e;
    if (oDONE) begin
      done_cnt++;
      check("busy_low_in_done", oBUSY, 0);
    end
    if (rd_pend) begin
      if (sbq.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = sbq.pop_front();
        tests++;
        if (oRD_VAL !== e.val) begin
          fails++;
          $display("FAIL rd_map[%0d]: got %0d expected %0d", e.addr, oRD_VAL, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(posedge iCLK); #1;
  endtask

  task automatic pix(input int x, input int y, input int d, input logic v);
    tick();
    iDVAL = v; iX = 13'(x); iY = 13'(y); iDATA = 10'(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin tick(); iDVAL = 1'b0; end
  endtask

  task automatic start();
    tick(); iDVAL = 1'b0; iSTART = 1'b1;
    tick(); iSTART = 1'b0;
  endtask

  task automatic rd(input int a, input int ev);
    tick();
    iDVAL = 1'b0; iRD_ADDR = 8'(a); rd_issue = 1'b1;
    sbq.push_back('{10'(ev), 8'(a)});
  endtask

  task automatic rd_end();
    tick(); rd_issue = 1'b0;
  endtask

  task automatic rd_all();
    for (int c = 0; c < 256; c++) rd(c, int'(exp_map[c]));
    rd_end();
  endtask

  // mode 0: flat 200; mode 1: dark disc r=24 at (64,64); mode 2: flat 128
  function automatic int frame_pix(input int mode, input int x, input int y);
    int dx, dy;
    dx = x - 64; dy = y - 64;
    case (mode)
      0:       return 200;
      1:       return (dx*dx + dy*dy <= 576) ? 10 : 220;
      default: return 128;
    endcase
  endfunction

  function automatic void build_exp(input int mode, input int th_top, input int th_bot);
    int sum, th;
    for (int c = 0; c < 256; c++) begin
      sum = 0;
      for (int yy = 0; yy < 8; yy++)
        for (int xx = 0; xx < 8; xx++)
          sum += frame_pix(mode, (c % 16)*8 + xx, (c / 16)*8 + yy);
      th = (c < 128) ? th_top : th_bot;
      exp_map[c] = ((sum >> 6) >= th) ? 10'd255 : 10'd0;
    end
  endfunction

  // Feeds the 128x128 window; stops before pixel (stop_x,stop_y) when given.
  task automatic frame(input int mode, input bit gaps, input int stop_x, input int stop_y);
    for (int y = 0; y < 128; y++) begin
      for (int x = 0; x < 128; x++) begin
        if (x == stop_x && y == stop_y) return;
        iTHRESH = (mode == 2 && y >= 66) ? 10'd129 : 10'd128;
        pix(x, y, frame_pix(mode, x, y), 1'b1);
        if (x == 0 && y == 64) check("busy_capt", oBUSY, 1);
        // Cell 37's last pixel is (47,23): a read two pixels later meets the write edge.
        if (mode == 2 && y == 23) begin
          if (x == 49) begin
            iRD_ADDR = 8'd37; rd_issue = 1'b1;
            sbq.push_back('{10'd0, 8'd37});
          end else if (x == 50) begin
            sbq.push_back('{10'd255, 8'd37});
          end else if (x == 51) begin
            rd_issue = 1'b0;
          end
        end
        if (gaps && (x % 8) == 7)
          pix($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 1023), 1'b0);
        if (gaps && x == 127) begin
          pix(128, y, 0, 1'b1);
          pix(128 + y, y, 0, 1'b1);
        end
      end
    end
  endtask

  initial begin
    int d0;
    iRST = 1'b1; iSTART = 1'b0; iDVAL = 1'b0; iX = '0; iY = '0;
    iDATA = '0; iTHRESH = 10'd128; iRD_ADDR = '0;
    idle(3);
    check("rst_busy", oBUSY, 0);
    check("rst_done", oDONE, 0);
    check("rst_rdval", oRD_VAL, 0);
    iRST = 1'b0;
    rd(5, 0); rd(255, 0); rd_end();

    // flat frame
    d0 = done_cnt;
    start();
    check("busy_armed", oBUSY, 1);
    frame(0, 1'b0, -1, -1);
    idle(6);
    check("flat_done_pulses", done_cnt - d0, 1);
    check("flat_busy_after", oBUSY, 0);
    build_exp(0, 128, 128);
    rd_all();

    // dark disc
    d0 = done_cnt;
    start();
    frame(1, 1'b0, -1, -1);
    idle(6);
    check("disc_done_pulses", done_cnt - d0, 1);
    rd(119, 0); rd(120, 0); rd(135, 0); rd(136, 0); rd(0, 255); rd_end();
    build_exp(1, 128, 128);
    rd_all();

    // same disc with invalid cycles and out-of-window pixels interleaved
    d0 = done_cnt;
    start();
    frame(1, 1'b1, -1, -1);
    idle(6);
    check("gaps_done_pulses", done_cnt - d0, 1);
    rd_all();

    // reset after cell 100 has been written
    d0 = done_cnt;
    start();
    frame(0, 1'b0, 45, 55);
    tick(); iDVAL = 1'b0; iRST = 1'b1;
    tick(); iRST = 1'b0;
    check("abort_busy", oBUSY, 0);
    check("abort_done", oDONE, 0);
    check("abort_rdval", oRD_VAL, 0);
    idle(3);
    check("abort_no_done", done_cnt - d0, 0);
    rd(0, 0); rd(50, 0); rd(99, 0); rd(100, 0); rd(101, 0); rd(255, 0); rd_end();

    // restart: avg exactly 128, iTHRESH 128 on top half and 129 on bottom half
    d0 = done_cnt;
    start();
    frame(2, 1'b0, -1, -1);
    idle(6);
    check("thr_done_pulses", done_cnt - d0, 1);
    build_exp(2, 128, 129);
    rd_all();

    idle(3);
    check("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
